// File: rtl/event_mm2s_cmd_arbiter.sv
// Shares one DataMover MM2S command/status channel between NREQ requesters:
// priority/round-robin command grant with tag stamping, status routed back by tag FIFO.
module event_mm2s_cmd_arbiter #(
   parameter int unsigned NREQ            = 2,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                   memclk,
   input  logic                                   memresetn,
   input  logic [72*NREQ-1:0]                     s_cmd_tdata,
   input  logic [NREQ-1:0]                        s_cmd_tvalid,
   output logic [NREQ-1:0]                        s_cmd_tready,
   output logic [71:0]                            m_cmd_tdata,
   output logic                                   m_cmd_tvalid,
   input  logic                                   m_cmd_tready,
   input  logic [7:0]                             s_sts_tdata,
   input  logic                                   s_sts_tvalid,
   output logic                                   s_sts_tready,
   output logic [7:0]                             m_sts_tdata,
   output logic [NREQ-1:0]                        m_sts_tvalid,
   input  logic [NREQ-1:0]                        m_sts_tready,
   output logic [$clog2(MAX_OUTSTANDING):0]       outstanding_o,
   input  logic                                   clear_err_i,
   output logic [2:0]                             err_o
);

   localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
   localparam int unsigned AW = $clog2(MAX_OUTSTANDING);
   localparam logic [71:0] KEEP_MASK = {8'h00, {64{1'b1}}};

   logic              run_q;
   logic [1:0]        seq_q, seq_d;
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic              m_cmd_tvalid_q, m_cmd_tvalid_d;
   logic [71:0]       m_cmd_tdata_q, m_cmd_tdata_d;
   logic [OW-1:0]     outstanding_q, outstanding_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [3:0]        tag_mem_q [MAX_OUTSTANDING];
   logic [3:0]        tag_mem_d [MAX_OUTSTANDING];
   logic [2:0]        err_q, err_d;

   logic [3:0]        vld_ext;
   logic [2:0]        cand;
   logic              win_valid;
   logic [1:0]        win_id;
   logic              load_en;
   logic              grant;
   logic [71:0]       sel_cmd;
   logic [3:0]        new_tag;

   logic              fifo_empty;
   logic [3:0]        head_tag;
   logic [1:0]        owner;
   logic [3:0]        sts_rdy_ext;
   logic              sts_hs;
   logic              pop;

   // Winner search: req 0 strict priority, others round-robin from rr_ptr
   always_comb begin
      vld_ext   = 4'(s_cmd_tvalid);
      win_valid = 1'b0;
      win_id    = 2'd0;
      cand      = 3'd0;
      if (vld_ext[0]) begin
         win_valid = 1'b1;
      end else begin
         for (int unsigned k = 0; k < NREQ - 1; k++) begin
            cand = 3'(rr_ptr_q) + 3'(k);
            if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ - 1);
            if (!win_valid && vld_ext[2'(cand)]) begin
               win_valid = 1'b1;
               win_id    = 2'(cand);
            end
         end
      end
   end

   assign load_en = run_q && (!m_cmd_tvalid_q || m_cmd_tready)
                    && (outstanding_q < OW'(MAX_OUTSTANDING));
   assign grant   = load_en && win_valid;
   assign new_tag = {seq_q, win_id};

   always_comb begin
      sel_cmd      = '0;
      s_cmd_tready = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win_id == 2'(i)) sel_cmd = s_cmd_tdata[72*i +: 72];
         s_cmd_tready[i] = grant && (win_id == 2'(i));
      end
   end

   // Status routing follows the oldest outstanding tag; orphans are sunk
   assign fifo_empty  = (outstanding_q == '0);
   assign head_tag    = tag_mem_q[rd_ptr_q];
   assign owner       = head_tag[1:0];
   assign sts_rdy_ext = 4'(m_sts_tready);
   assign s_sts_tready = fifo_empty || sts_rdy_ext[owner];
   assign m_sts_tdata  = s_sts_tdata;
   assign sts_hs       = s_sts_tvalid && s_sts_tready;
   assign pop          = sts_hs && !fifo_empty;

   always_comb begin
      m_sts_tvalid = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         m_sts_tvalid[i] = s_sts_tvalid && !fifo_empty && (owner == 2'(i));
      end
   end

   always_comb begin
      seq_d          = seq_q;
      rr_ptr_d       = rr_ptr_q;
      m_cmd_tvalid_d = m_cmd_tvalid_q;
      m_cmd_tdata_d  = m_cmd_tdata_q;
      outstanding_d  = outstanding_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      tag_mem_d      = tag_mem_q;
      err_d          = clear_err_i ? 3'b000 : err_q;

      if (grant) begin
         seq_d                = seq_q + 2'd1;
         m_cmd_tvalid_d       = 1'b1;
         m_cmd_tdata_d        = (sel_cmd & KEEP_MASK) | {4'h0, new_tag, 64'h0};
         tag_mem_d[wr_ptr_q]  = new_tag;
         wr_ptr_d             = wr_ptr_q + AW'(1);
         if (win_id != 2'd0) begin
            rr_ptr_d = (win_id == 2'(NREQ - 1)) ? 2'd1 : win_id + 2'd1;
         end
      end else if (m_cmd_tready) begin
         m_cmd_tvalid_d = 1'b0;
      end

      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

      case ({grant, pop})
         2'b10:   outstanding_d = outstanding_q + OW'(1);
         2'b01:   outstanding_d = outstanding_q - OW'(1);
         default: outstanding_d = outstanding_q;
      endcase

      // Error set has priority over a same-cycle clear
      if (sts_hs && fifo_empty) err_d[0] = 1'b1;
      if (pop && (s_sts_tdata[3:0] != head_tag)) err_d[1] = 1'b1;
      if (sts_hs && (!s_sts_tdata[7] || (|s_sts_tdata[6:4]))) err_d[2] = 1'b1;
   end

   always_ff @(posedge memclk or negedge memresetn) begin
      if (!memresetn) begin
         run_q          <= 1'b0;
         seq_q          <= 2'd0;
         rr_ptr_q       <= 2'd1;
         m_cmd_tvalid_q <= 1'b0;
         m_cmd_tdata_q  <= '0;
         outstanding_q  <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         err_q          <= 3'b000;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) tag_mem_q[i] <= 4'h0;
      end else begin
         run_q          <= 1'b1;
         seq_q          <= seq_d;
         rr_ptr_q       <= rr_ptr_d;
         m_cmd_tvalid_q <= m_cmd_tvalid_d;
         m_cmd_tdata_q  <= m_cmd_tdata_d;
         outstanding_q  <= outstanding_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         err_q          <= err_d;
         tag_mem_q      <= tag_mem_d;
      end
   end

   assign m_cmd_tvalid  = m_cmd_tvalid_q;
   assign m_cmd_tdata   = m_cmd_tdata_q;
   assign outstanding_o = outstanding_q;
   assign err_o         = err_q;

endmodule
